// File: rtl/oqpsk_rx_demod_if.sv
// ---------------------------------------------------------------------------
// oqpsk_rx_demod_if
// Sample/decision bundle between the I/Q source and the OQPSK demodulator.
//   master : drives EN, ALIGN, I_in, Q_in; observes the bit/lock outputs
//   slave  : the demodulator side
// Signals:
//   EN        sample enable (all demod state holds when low)
//   ALIGN     one-cycle pulse restarting symbol timing
//   I_in/Q_in signed DW-bit baseband samples
//   BitOut    recovered bit, BitValid its one-cycle strobe
//   Lock      demodulator is in LOCK
//   DecI/DecQ most recent I / Q hard decisions
// ---------------------------------------------------------------------------
interface oqpsk_rx_demod_if #(
    parameter int DW = 13
);
    logic                 EN;
    logic                 ALIGN;
    logic signed [DW-1:0] I_in;
    logic signed [DW-1:0] Q_in;
    logic                 BitOut;
    logic                 BitValid;
    logic                 Lock;
    logic                 DecI;
    logic                 DecQ;

    modport master (
        output EN, ALIGN, I_in, Q_in,
        input  BitOut, BitValid, Lock, DecI, DecQ
    );

    modport slave (
        input  EN, ALIGN, I_in, Q_in,
        output BitOut, BitValid, Lock, DecI, DecQ
    );
endinterface

// File: rtl/oqpsk_rx_demod.sv
// ---------------------------------------------------------------------------
// oqpsk_rx_demod
// OQPSK receive demodulator: integrate-and-dump over SAMPLES-clock windows,
// the Q window offset by half a symbol, hard sign decisions, a lock FSM that
// gates output validity, and re-serialisation to an I,Q,I,Q... bitstream.
// Ports:
//   CLK50M  50 MHz clock
//   RST     asynchronous reset, active low
//   bus     oqpsk_rx_demod_if.slave (EN, ALIGN, I_in, Q_in in;
//           BitOut, BitValid, Lock, DecI, DecQ out)
// ---------------------------------------------------------------------------
module oqpsk_rx_demod #(
    parameter int DW       = 13,
    parameter int SAMPLES  = 50,
    parameter int ACC_W    = 19,
    parameter int THRESH   = 20000,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 8
) (
    input  logic              CLK50M,
    input  logic              RST,
    oqpsk_rx_demod_if.slave   bus
);
    localparam int CTR_W  = $clog2(SAMPLES);
    localparam int QUAL_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_CNT + 1);

    localparam logic [CTR_W-1:0] CTR_I_LAST = CTR_W'(SAMPLES - 1);
    localparam logic [CTR_W-1:0] CTR_Q_LAST = CTR_W'(SAMPLES / 2 - 1);

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCK   = 1'b1;

    logic [CTR_W-1:0]         r_ctr;
    logic signed [ACC_W-1:0]  r_acc_i;
    logic signed [ACC_W-1:0]  r_acc_q;
    logic [0:0]               r_state;
    logic [QUAL_W-1:0]        r_qual;
    logic [MISS_W-1:0]        r_miss;
    logic                     r_q_first;
    logic                     r_bit_out;
    logic                     r_bit_valid;
    logic                     r_dec_i;
    logic                     r_dec_q;

    logic signed [ACC_W-1:0]  w_i_ext;
    logic signed [ACC_W-1:0]  w_q_ext;
    logic signed [ACC_W-1:0]  w_sum_i;
    logic signed [ACC_W-1:0]  w_sum_q;
    logic signed [ACC_W-1:0]  w_sum_sel;
    logic [ACC_W:0]           w_sum_wide;
    logic [ACC_W:0]           w_abs;
    logic                     w_dump_i;
    logic                     w_dump_q;
    logic                     w_counted;
    logic                     w_qualify;
    logic                     w_decision;

    always_comb begin
        w_i_ext    = {{(ACC_W-DW){bus.I_in[DW-1]}}, bus.I_in};
        w_q_ext    = {{(ACC_W-DW){bus.Q_in[DW-1]}}, bus.Q_in};
        w_sum_i    = r_acc_i + w_i_ext;
        w_sum_q    = r_acc_q + w_q_ext;
        w_dump_i   = (r_ctr == CTR_I_LAST);
        w_dump_q   = (r_ctr == CTR_Q_LAST);
        // The two dumps never coincide, so one shared decision path suffices.
        w_sum_sel  = w_dump_i ? w_sum_i : w_sum_q;
        // One extra bit so that the magnitude of the most negative sum fits.
        w_sum_wide = {w_sum_sel[ACC_W-1], w_sum_sel};
        w_abs      = w_sum_wide[ACC_W] ? (~w_sum_wide + (ACC_W+1)'(1)) : w_sum_wide;
        w_qualify  = (w_abs >= (ACC_W+1)'(THRESH));
        w_decision = ~w_sum_sel[ACC_W-1];
        // The first Q dump after restart only spans half a window.
        w_counted  = w_dump_i | (w_dump_q & ~r_q_first);
    end

    always_ff @(posedge CLK50M or negedge RST) begin
        if (!RST) begin
            r_ctr       <= '0;
            r_acc_i     <= '0;
            r_acc_q     <= '0;
            r_state     <= ST_SEARCH;
            r_qual      <= '0;
            r_miss      <= '0;
            r_q_first   <= 1'b1;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_dec_i     <= 1'b0;
            r_dec_q     <= 1'b0;
        end else if (bus.ALIGN) begin
            r_ctr       <= '0;
            r_acc_i     <= '0;
            r_acc_q     <= '0;
            r_state     <= ST_SEARCH;
            r_qual      <= '0;
            r_miss      <= '0;
            r_q_first   <= 1'b1;
            r_bit_valid <= 1'b0;
        end else if (bus.EN) begin
            r_bit_valid <= 1'b0;
            r_ctr       <= w_dump_i ? '0 : r_ctr + CTR_W'(1);
            r_acc_i     <= w_dump_i ? '0 : w_sum_i;
            r_acc_q     <= w_dump_q ? '0 : w_sum_q;

            if (w_dump_i)
                r_dec_i <= w_decision;
            if (w_dump_q) begin
                if (r_q_first)
                    r_q_first <= 1'b0;
                else
                    r_dec_q <= w_decision;
            end

            if (w_counted) begin
                if (r_state == ST_SEARCH) begin
                    // The dump completing lock is not emitted.
                    if (!w_qualify) begin
                        r_qual <= '0;
                    end else if (r_qual == QUAL_W'(LOCK_CNT - 1)) begin
                        r_state <= ST_LOCK;
                        r_qual  <= '0;
                        r_miss  <= '0;
                    end else begin
                        r_qual <= r_qual + QUAL_W'(1);
                    end
                end else begin
                    // In LOCK every counted dump is emitted, including the
                    // one that drops lock.
                    r_bit_out   <= w_decision;
                    r_bit_valid <= 1'b1;
                    if (w_qualify) begin
                        r_miss <= '0;
                    end else if (r_miss == MISS_W'(LOSS_CNT - 1)) begin
                        r_state <= ST_SEARCH;
                        r_qual  <= '0;
                        r_miss  <= '0;
                    end else begin
                        r_miss <= r_miss + MISS_W'(1);
                    end
                end
            end
        end else begin
            r_bit_valid <= 1'b0;
        end
    end

    assign bus.BitOut   = r_bit_out;
    assign bus.BitValid = r_bit_valid;
    assign bus.Lock     = (r_state == ST_LOCK);
    assign bus.DecI     = r_dec_i;
    assign bus.DecQ     = r_dec_q;

endmodule

// File: tb/tb_oqpsk_rx_demod.sv
// ---------------------------------------------------------------------------
// tb_oqpsk_rx_demod
// Directed bench for oqpsk_rx_demod: reset/idle, lock entry with constant
// drive, loss of lock, EN gating, ALIGN with EN low, and an async reset
// pulse mid-window. Expected values are hand-computed from the window sums.
// ---------------------------------------------------------------------------
module tb_oqpsk_rx_demod;
    logic clk;
    logic rst_n;

    int compared;
    int mismatched;
    int strobes;
    int ones;
    int sidx [0:7];

    oqpsk_rx_demod_if #(.DW(13)) bus ();

    oqpsk_rx_demod dut (
        .CLK50M (clk),
        .RST    (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs n clock edges; inputs change and outputs are sampled on the
    // falling edge. With toggle set, EN is high on odd-numbered edges only.
    task automatic run(input int n, input bit toggle);
        strobes = 0;
        ones    = 0;
        for (int k = 1; k <= n; k++) begin
            if (toggle)
                bus.EN = (k % 2 == 1);
            @(posedge clk);
            @(negedge clk);
            if (bus.BitValid) begin
                if (strobes < 8)
                    sidx[strobes] = k;
                strobes++;
                if (bus.BitOut)
                    ones++;
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b1;
        bus.EN     = 1'b0;
        bus.ALIGN  = 1'b0;
        bus.I_in   = '0;
        bus.Q_in   = '0;
        #1 rst_n   = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_bitout",   32'(bus.BitOut),   0);
        check("rst_bitvalid", 32'(bus.BitValid), 0);
        check("rst_lock",     32'(bus.Lock),     0);
        check("rst_deci",     32'(bus.DecI),     0);
        check("rst_decq",     32'(bus.DecQ),     0);

        // Idle with EN low: nothing moves
        rst_n = 1'b1;
        run(100, 0);
        check("idle_strobes", 32'(strobes),  0);
        check("idle_lock",    32'(bus.Lock), 0);
        check("idle_deci",    32'(bus.DecI), 0);

        // Lock entry, I=+1000 Q=-1000; counter starts at 0 from reset, so the
        // partial Q dump is at edge 25 and counted dumps at 50/75/100/125.
        bus.EN   = 1'b1;
        bus.I_in = 13'sd1000;
        bus.Q_in = -13'sd1000;
        run(50, 0);
        check("lk_deci_first", 32'(bus.DecI), 1);
        check("lk_strobes_50", 32'(strobes),  0);
        run(50, 0);
        check("lk_lock_100",   32'(bus.Lock), 0);
        run(24, 0);
        check("lk_lock_124",   32'(bus.Lock), 0);
        run(1, 0);
        check("lk_lock_125",   32'(bus.Lock), 1);
        check("lk_nostrobe",   32'(strobes),  0);
        check("lk_decq",       32'(bus.DecQ), 0);
        run(24, 0);
        check("lk_gap",        32'(strobes),  0);
        run(1, 0);
        check("lk_valid_i",    32'(bus.BitValid), 1);
        check("lk_bit_i",      32'(bus.BitOut),   1);
        run(24, 0);
        check("lk_gap2",       32'(strobes),  0);
        run(1, 0);
        check("lk_valid_q",    32'(bus.BitValid), 1);
        check("lk_bit_q",      32'(bus.BitOut),   0);

        // Loss of lock, I=Q=+100: I dump at edge 200 still sums 27500 (25
        // samples of 1000), then eight 5000 dumps drop lock at edge 400.
        bus.I_in = 13'sd100;
        bus.Q_in = 13'sd100;
        run(224, 0);
        check("loss_strobes",  32'(strobes),  8);
        check("loss_ones",     32'(ones),     8);
        check("loss_lock_hi",  32'(bus.Lock), 1);
        run(1, 0);
        check("loss_lastv",    32'(bus.BitValid), 1);
        check("loss_lastb",    32'(bus.BitOut),   1);
        check("loss_lock_lo",  32'(bus.Lock),     0);
        run(100, 0);
        check("loss_silent",   32'(strobes),  0);

        // ALIGN with EN high, relock with I=-700 (sum -35000) Q=-1000
        bus.I_in  = -13'sd700;
        bus.Q_in  = -13'sd1000;
        bus.ALIGN = 1'b1;
        run(1, 0);
        bus.ALIGN = 1'b0;
        run(125, 0);
        check("en_lock",       32'(bus.Lock), 1);
        check("en_nostrobe",   32'(strobes),  0);
        check("en_deci",       32'(bus.DecI), 0);

        // EN toggling: ctr=25, dumps every 25 enabled = 50 real clocks
        run(200, 1);
        check("en_strobes",    32'(strobes),  4);
        check("en_ones",       32'(ones),     0);
        check("en_idx0",       32'(sidx[0]),  49);
        check("en_idx1",       32'(sidx[1]),  99);
        check("en_idx2",       32'(sidx[2]),  149);
        check("en_idx3",       32'(sidx[3]),  199);

        // ALIGN at ctr=30 while EN is low
        bus.EN = 1'b1;
        run(5, 0);
        check("al_lock_pre",   32'(bus.Lock), 1);
        bus.I_in  = 13'sd1000;
        bus.Q_in  = -13'sd1000;
        bus.EN    = 1'b0;
        bus.ALIGN = 1'b1;
        run(1, 0);
        bus.ALIGN = 1'b0;
        check("al_lock_drop",  32'(bus.Lock),     0);
        check("al_novalid",    32'(bus.BitValid), 0);
        bus.EN = 1'b1;
        run(124, 0);
        check("al_lock_124",   32'(bus.Lock), 0);
        run(1, 0);
        check("al_lock_125",   32'(bus.Lock), 1);
        run(25, 0);
        check("al_valid_i",    32'(bus.BitValid), 1);
        check("al_bit_i",      32'(bus.BitOut),   1);
        check("al_deci",       32'(bus.DecI),     1);

        // Async reset pulse mid-window
        run(10, 0);
        rst_n = 1'b0;
        #1;
        check("ar_lock",       32'(bus.Lock),     0);
        check("ar_deci",       32'(bus.DecI),     0);
        check("ar_bitout",     32'(bus.BitOut),   0);
        check("ar_bitvalid",   32'(bus.BitValid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(124, 0);
        check("ar_lock_124",   32'(bus.Lock), 0);
        run(1, 0);
        check("ar_lock_125",   32'(bus.Lock), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
